// File: rtl/pht_pkg.sv
// Shared types and helpers for the branch pattern history table update path.
package pht_pkg;

  localparam int PHT_IDX_W   = 5;
  localparam int PHT_ENTRIES = 32;

  typedef logic [PHT_IDX_W-1:0] pht_idx_t;
  typedef logic [1:0]           pht_ctr_t;

  // Weakly not-taken.
  localparam pht_ctr_t PHT_INIT = 2'b01;
  localparam pht_idx_t PHT_LAST = pht_idx_t'(PHT_ENTRIES - 1);

  // One resolved-branch update as queued from the backend.
  typedef struct packed {
    pht_idx_t idx;
    logic     taken;
  } pht_upd_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_t;

  // 2-bit saturating counter step: up on taken, down on not-taken.
  function automatic pht_ctr_t pht_sat_update(pht_ctr_t ctr, logic taken);
    pht_ctr_t res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small synchronous FIFO holding pending PHT updates; wrap-bit pointers
// distinguish full from empty without a separate occupancy counter.
module pht_upd_fifo
  import pht_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  logic     pop_i,
  input  pht_upd_t din_i,
  output pht_upd_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(QDEPTH);

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  pht_upd_t    mem_q [QDEPTH];
  pht_upd_t    mem_d [QDEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer values and storage contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PW-1:0]] = din_i;
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end
  end

  // Pointer registers; reset empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pht_update_unit.sv
// Read-modify-write engine for the 32x2 pattern history table: sweeps the
// RAM to a known value after reset, then applies queued branch outcomes.
module pht_update_unit
  import pht_pkg::*;
#(
  parameter int       QDEPTH   = 4,
  parameter pht_ctr_t INIT_VAL = PHT_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       upd_valid_i,
  output logic       upd_ready_o,
  input  logic [4:0] upd_idx_i,
  input  logic       upd_taken_i,
  input  logic       ram_gnt_i,
  output logic [4:0] ram_ra_o,
  input  logic [1:0] ram_rd_i,
  output logic       ram_we_o,
  output logic [4:0] ram_aw_o,
  output logic [1:0] ram_di_o,
  output logic       init_done_o
);

  pht_state_t state_q, state_d;
  pht_idx_t   cnt_q, cnt_d;
  logic       s1_valid_q, s1_valid_d;
  pht_idx_t   s1_idx_q, s1_idx_d;
  pht_ctr_t   s1_next_q, s1_next_d;

  pht_upd_t   fifo_din;
  pht_upd_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       pop;
  logic       fwd_hit;
  pht_ctr_t   old_val;
  pht_ctr_t   new_val;
  logic       init_wr;

  assign init_done_o = (state_q == ST_RUN);
  assign upd_ready_o = init_done_o && !fifo_full;
  assign fifo_push   = upd_valid_i && upd_ready_o;
  assign fifo_din    = '{idx: upd_idx_i, taken: upd_taken_i};

  pht_upd_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // S0: read the head entry's counter, forwarding the pending S1 write when
  // it targets the same index so back-to-back updates see the newest value.
  always_comb begin
    ram_ra_o = fifo_empty ? '0 : head.idx;
    pop      = init_done_o && !fifo_empty && (!s1_valid_q || ram_gnt_i);
    fwd_hit  = s1_valid_q && (s1_idx_q == head.idx);
    old_val  = fwd_hit ? s1_next_q : ram_rd_i;
    new_val  = pht_sat_update(old_val, head.taken);
  end

  // Next-state logic: the sweep counter only advances on committed writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (ram_gnt_i) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == PHT_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // S1 write register: loads on pop, holds without grant, empties once the
  // write has committed and nothing new arrived behind it.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_idx_d   = s1_idx_q;
    s1_next_d  = s1_next_q;
    if (pop) begin
      s1_valid_d = 1'b1;
      s1_idx_d   = head.idx;
      s1_next_d  = new_val;
    end else if (s1_valid_q && ram_gnt_i) begin
      s1_valid_d = 1'b0;
    end
  end

  // Write port: during the sweep the S1 outputs carry (cnt, INIT_VAL); all
  // write outputs are forced quiet while reset is held.
  always_comb begin
    init_wr  = (state_q == ST_INIT) && !rst;
    ram_we_o = 1'b0;
    ram_aw_o = s1_idx_q;
    ram_di_o = s1_next_q;
    if (init_wr) begin
      ram_we_o = ram_gnt_i;
      ram_aw_o = cnt_q;
      ram_di_o = INIT_VAL;
    end else if (init_done_o) begin
      ram_we_o = s1_valid_q && ram_gnt_i;
    end
  end

  // State, sweep counter and S1 registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_next_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_next_q  <= s1_next_d;
    end
  end

endmodule

// File: tb/tb_pht_update_unit.sv
module tb_pht_update_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_valid;
  logic       upd_ready;
  logic [4:0] upd_idx;
  logic       upd_taken;
  logic       ram_gnt;
  logic [4:0] ram_ra;
  logic [1:0] ram_rd;
  logic       ram_we;
  logic [4:0] ram_aw;
  logic [1:0] ram_di;
  logic       init_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural RAM (no reset) and golden table contents.
  logic [1:0] ram    [32];
  logic [1:0] golden [32];

  typedef struct {
    logic [4:0] idx;
    logic [1:0] val;
    int         cyc;
  } wr_t;

  wr_t exp_q   [$];
  wr_t run_log [$];

  typedef struct {
    logic [4:0] idx;
    logic       taken;
    logic [1:0] exp_di;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  pht_update_unit #(
    .QDEPTH   (4),
    .INIT_VAL (2'b01)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid_i (upd_valid),
    .upd_ready_o (upd_ready),
    .upd_idx_i   (upd_idx),
    .upd_taken_i (upd_taken),
    .ram_gnt_i   (ram_gnt),
    .ram_ra_o    (ram_ra),
    .ram_rd_i    (ram_rd),
    .ram_we_o    (ram_we),
    .ram_aw_o    (ram_aw),
    .ram_di_o    (ram_di),
    .init_done_o (init_done)
  );

  assign ram_rd = ram[ram_ra];

  always @(posedge clk) begin
    if (ram_we) ram[ram_aw] <= ram_di;
  end

  function automatic logic [1:0] model_next(input logic [1:0] c, input logic t);
    int v;
    v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every accepted update produces exactly one write, in order.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) golden[i] = 2'b01;
    end else begin
      if (init_done && ram_we) begin
        run_log.push_back('{ram_aw, ram_di, cyc});
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=aw%0d/di%0d required=none", ram_aw, ram_di);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_vs_model", {25'd0, ram_aw, ram_di}, {25'd0, e.idx, e.val});
        end
      end
      if (upd_valid && upd_ready) begin
        golden[upd_idx] = model_next(golden[upd_idx], upd_taken);
        exp_q.push_back('{upd_idx, golden[upd_idx], 0});
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic g);
    rst       = 1'b1;
    upd_valid = 1'b0;
    upd_idx   = '0;
    upd_taken = 1'b0;
    ram_gnt   = g;
    #1;
    chk("rst_we",    {31'd0, ram_we},    32'd0);
    chk("rst_ready", {31'd0, upd_ready}, 32'd0);
    chk("rst_done",  {31'd0, init_done}, 32'd0);
    chk("rst_aw_di_ra", {20'd0, ram_aw, ram_di, ram_ra}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic sweep_gnt1(input string name);
    int ok = 0;
    ram_gnt = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (ram_we && ram_aw == 5'(i) && ram_di == 2'b01 && !init_done) ok++;
      tick();
    end
    chk(name, ok, 32);
  endtask

  task automatic idle(input int n);
    upd_valid = 1'b0;
    ram_gnt   = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int sweep_cycles;
    int ready_seen [6];
    logic [4:0] init_aw [$];

    tbl[0] = '{5'd5, 1'b1, 2'b11};
    tbl[1] = '{5'd7, 1'b1, 2'b10};
    tbl[2] = '{5'd7, 1'b1, 2'b11};
    tbl[3] = '{5'd7, 1'b1, 2'b11};
    tbl[4] = '{5'd9, 1'b0, 2'b00};
    tbl[5] = '{5'd9, 1'b0, 2'b00};
    tbl[6] = '{5'd9, 1'b0, 2'b00};
    tbl[7] = '{5'd9, 1'b1, 2'b01};

    // Reset and sweep with a permanent grant.
    do_reset(1'b1);
    sweep_gnt1("sweep_aw_seq");
    #1;
    chk("cycle33_done",  {31'd0, init_done}, 32'd1);
    chk("cycle33_ready", {31'd0, upd_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== 2'b01) bad++;
    chk("ram_after_sweep", bad, 0);

    // Single update latency: idx 5 taken.
    upd_valid = 1'b1; upd_idx = 5'd5; upd_taken = 1'b1;
    #1;
    chk("t2_handshake", {31'd0, upd_ready}, 32'd1);
    tick();
    upd_valid = 1'b0;
    #1;
    chk("t2_head_ra", {27'd0, ram_ra}, 32'd5);
    chk("t2_c1_we",   {31'd0, ram_we}, 32'd0);
    tick();
    #1;
    chk("t2_c2_write", {24'd0, ram_we, ram_aw, ram_di}, {24'd0, 1'b1, 5'd5, 2'b10});
    tick();
    #1;
    chk("t2_c3_ram", {30'd0, ram[5]}, 32'd2);
    idle(3);

    // Table: back-to-back updates with forwarding and saturation at 3 / 0.
    run_log.delete();
    for (int i = 0; i < 8; i++) begin
      upd_valid = 1'b1; upd_idx = tbl[i].idx; upd_taken = tbl[i].taken;
      tick();
    end
    idle(6);
    chk("tbl_count", run_log.size(), 8);
    for (int i = 0; i < 8 && i < run_log.size(); i++) begin
      chk($sformatf("tbl%0d_aw", i), {27'd0, run_log[i].idx}, {27'd0, tbl[i].idx});
      chk($sformatf("tbl%0d_di", i), {30'd0, run_log[i].val}, {30'd0, tbl[i].exp_di});
      chk($sformatf("tbl%0d_cyc", i), run_log[i].cyc - run_log[0].cyc, i);
    end

    // Stall: grant low, six push attempts, five accepted.
    run_log.delete();
    ram_gnt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      upd_valid = 1'b1; upd_idx = 5'(10 + k); upd_taken = k[0];
      #1;
      ready_seen[k] = int'(upd_ready);
      tick();
    end
    upd_valid = 1'b0;
    for (int k = 0; k < 6; k++)
      chk($sformatf("t5_ready%0d", k), ready_seen[k], (k < 5) ? 1 : 0);
    tick();
    #1;
    chk("t5_stalled_we", {31'd0, ram_we}, 32'd0);
    ram_gnt = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_count", run_log.size(), 5);
    for (int i = 0; i < 5 && i < run_log.size(); i++) begin
      chk($sformatf("t5_order%0d", i), {27'd0, run_log[i].idx}, 32'(10 + i));
      chk($sformatf("t5_cyc%0d", i), run_log[i].cyc - run_log[0].cyc, i);
    end

    // Randomized traffic on a few hot indices with random grant stalls.
    for (int n = 0; n < 400; n++) begin
      upd_valid = 1'($urandom_range(0, 1));
      upd_idx   = 5'($urandom_range(0, 3) + (($urandom_range(0, 7) == 0) ? 20 : 0));
      upd_taken = 1'($urandom_range(0, 1));
      ram_gnt   = ($urandom_range(0, 3) != 0);
      tick();
    end
    upd_valid = 1'b0;
    ram_gnt   = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("rand_drained", exp_q.size(), 0);
    tick();
    bad = 0;
    for (int i = 0; i < 32; i++) if (ram[i] !== golden[i]) bad++;
    chk("rand_final_contents", bad, 0);

    // Reset mid-queue discards pending updates and restarts the sweep.
    ram_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      upd_valid = 1'b1; upd_idx = 5'(20 + k); upd_taken = 1'b0;
      tick();
    end
    upd_valid = 1'b0;
    tick();
    ram_gnt = 1'b1;
    #1;
    chk("t6_we_before", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_we_drop",   {31'd0, ram_we},    32'd0);
    chk("t6_done_drop", {31'd0, init_done}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    run_log.delete();
    sweep_gnt1("t6_resweep");
    idle(6);
    chk("t6_no_stale_writes", run_log.size(), 0);
    chk("t6_ram20_22", {26'd0, ram[20], ram[21], ram[22]}, 32'b010101);

    // Sweep with alternating grant: 64 cycles, no index skipped.
    do_reset(1'b0);
    sweep_cycles = -1;
    for (int k = 1; k <= 200; k++) begin
      ram_gnt = (k % 2 == 0);
      #1;
      if (init_done) begin
        sweep_cycles = k - 1;
        break;
      end
      if (ram_we) init_aw.push_back(ram_aw);
      tick();
    end
    chk("toggle_sweep_cycles", sweep_cycles, 64);
    bad = (init_aw.size() == 32) ? 0 : 1;
    for (int i = 0; i < init_aw.size() && i < 32; i++) if (init_aw[i] != 5'(i)) bad++;
    chk("toggle_no_skip", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
